// File: rtl/fifo_arb_pkg.sv
// Shared types for the fifo write-port arbiters.
// Header word layout helper lives here so the host demux and RTL agree.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BURST
  } state_t;

  function automatic logic [31:0] hdr_word(
    input logic [31:0] magic,
    input logic [31:0] ch,
    input int          ch_w
  );
    return (magic << ch_w) | ch;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches last+1, last+2, .. (mod N) and returns the first set request.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);

  int c;

  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last) + i) % N;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = W'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the single fifo write port.
// Optional channel-ID header word precedes every burst.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int          N_CH      = 4,
  parameter  int          DW        = 8,
  parameter  int          MAX_BURST = 64,
  parameter  bit          HEADER_EN = 1'b1,
  parameter  logic [31:0] HDR_MAGIC = 32'hA,
  localparam int          CH_W      = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH*DW-1:0] data,
  output logic [N_CH-1:0]  gnt,
  output logic             fifo_wreq,
  output logic [DW-1:0]    fifo_wdata,
  input  logic             fifo_wgnt,
  output logic             busy,
  output logic [CH_W-1:0]  cur_ch
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_t          state;
  logic [CH_W-1:0] last;
  logic [BW-1:0]   beat_cnt;

  logic            pick_any;
  logic [CH_W-1:0] pick_idx;
  logic            own_req;
  logic [DW-1:0]   own_data;
  logic [31:0]     hdr_full;
  logic [DW-1:0]   hdr;
  logic            acc;
  logic            last_beat;

  rr_pick #(.N(N_CH)) u_pick (
    .req  (req),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign own_req   = req[cur_ch];
  assign own_data  = data[cur_ch*DW +: DW];
  assign hdr_full  = hdr_word(HDR_MAGIC, 32'(cur_ch), CH_W);
  assign hdr       = hdr_full[DW-1:0];
  assign acc       = (state == BURST) && own_req && fifo_wgnt;
  assign last_beat = beat_cnt == BW'(MAX_BURST - 1);
  assign busy      = state != IDLE;

  always_comb begin
    fifo_wreq  = 1'b0;
    fifo_wdata = '0;
    gnt        = '0;
    unique case (state)
      HDR: begin
        fifo_wreq  = 1'b1;
        fifo_wdata = hdr;
      end
      BURST: begin
        fifo_wreq   = own_req;
        fifo_wdata  = own_data;
        gnt[cur_ch] = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= CH_W'(N_CH - 1);
      cur_ch   <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            cur_ch   <= pick_idx;
            beat_cnt <= '0;
            state    <= HEADER_EN ? HDR : BURST;
          end
        end
        HDR: begin
          if (fifo_wgnt) state <= BURST;
        end
        BURST: begin
          if (!own_req || (acc && last_beat)) begin
            state    <= IDLE;
            last     <= cur_ch;
            beat_cnt <= '0;
          end else if (acc) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: stimulus queues expected fifo writes, monitor pops them.
// d0: HEADER_EN=1, d1: HEADER_EN=0; both MAX_BURST=4, N_CH=4, DW=8.
module tb_fifo_wr_arbiter;

  localparam logic [7:0] HDR_BASE = 8'h28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tot[2][4];
  int taken[2][4];
  int base[2][4];

  logic [3:0]  req_v[2];
  logic [3:0]  gnt_v[2];
  logic [31:0] data_v[2];
  logic [7:0]  wdata_v[2];
  logic [1:0]  cur_v[2];
  logic [1:0]  wreq;
  logic [1:0]  wgnt;
  logic [1:0]  busy;
  logic [1:0]  full_n = 2'b11;

  int passed = 0;
  int total  = 0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  assign wgnt = wreq & full_n;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      req_v[d]  = '0;
      data_v[d] = '0;
      for (int i = 0; i < 4; i++) begin
        req_v[d][i] = taken[d][i] < tot[d][i];
        data_v[d][i*8 +: 8] = 8'(i * 16 + taken[d][i] - base[d][i]);
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        if (gnt_v[d][i]) taken[d][i] <= taken[d][i] + 1;
  end

  fifo_wr_arbiter #(
    .N_CH(4), .DW(8), .MAX_BURST(4),
    .HEADER_EN(1'b1), .HDR_MAGIC(32'hA)
  ) u_d0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_v[0]),
    .data       (data_v[0]),
    .gnt        (gnt_v[0]),
    .fifo_wreq  (wreq[0]),
    .fifo_wdata (wdata_v[0]),
    .fifo_wgnt  (wgnt[0]),
    .busy       (busy[0]),
    .cur_ch     (cur_v[0])
  );

  fifo_wr_arbiter #(
    .N_CH(4), .DW(8), .MAX_BURST(4),
    .HEADER_EN(1'b0), .HDR_MAGIC(32'hA)
  ) u_d1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_v[1]),
    .data       (data_v[1]),
    .gnt        (gnt_v[1]),
    .fifo_wreq  (wreq[1]),
    .fifo_wdata (wdata_v[1]),
    .fifo_wgnt  (wgnt[1]),
    .busy       (busy[1]),
    .cur_ch     (cur_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic mon(input int d);
    logic [11:0] e;
    logic [11:0] a;
    if (wreq[d] && wgnt[d]) begin
      a = {gnt_v[d], wdata_v[d]};
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        total++;
        $display("FAIL d%0d unexpected write: got %0h expected none", d, a);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("d%0d gnt/wdata", d), 32'(a), 32'(e));
      end
    end
  endtask

  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic push(input int d, input logic [3:0] g, input logic [7:0] w);
    if (d == 0) q0.push_back({g, w});
    else        q1.push_back({g, w});
  endtask

  task automatic hdr(input int d, input int ch);
    push(d, 4'h0, HDR_BASE | 8'(ch));
  endtask

  task automatic word(input int d, input int ch, input int k);
    push(d, 4'(1 << ch), 8'(ch * 16 + k));
  endtask

  task automatic load(input int d, input int ch, input int n);
    base[d][ch] = taken[d][ch];
    tot[d][ch]  = taken[d][ch] + n;
  endtask

  function automatic bit pend(input int d);
    for (int i = 0; i < 4; i++)
      if (taken[d][i] < tot[d][i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input int d, input int exp, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[d] || pend(d)) && n < 300);
    chk(name, 32'(n), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst d%0d busy", d), 32'(busy[d]), 0);
      chk($sformatf("rst d%0d wreq", d), 32'(wreq[d]), 0);
      chk($sformatf("rst d%0d gnt", d), 32'(gnt_v[d]), 0);
      chk($sformatf("rst d%0d cur_ch", d), 32'(cur_v[d]), 0);
      chk($sformatf("rst d%0d wdata", d), 32'(wdata_v[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // single channel stream
    hdr(0, 2);
    for (int k = 0; k < 3; k++) word(0, 2, k);
    load(0, 2, 3);
    wait_idle(0, 6, "t1 cycles");
    chk("t1 busy", 32'(busy[0]), 0);
    chk("t1 cur_ch", 32'(cur_v[0]), 2);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // all channels, burst cap rotation
    for (int c = 0; c < 4; c++) begin
      hdr(0, c);
      for (int k = 0; k < 4; k++) word(0, c, k);
    end
    hdr(0, 0);
    for (int k = 4; k < 8; k++) word(0, 0, k);
    load(0, 0, 8);
    for (int c = 1; c < 4; c++) load(0, c, 4);
    wait_idle(0, 30, "t2 cycles");

    // fifo full mid-burst
    hdr(0, 1);
    for (int k = 0; k < 4; k++) word(0, 1, k);
    load(0, 1, 4);
    repeat (4) @(negedge clk);
    full_n[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t3 stall wreq", 32'(wreq[0]), 1);
      chk("t3 stall gnt", 32'(gnt_v[0]), 0);
      @(negedge clk);
    end
    chk("t3 beat_cnt", 32'(u_d0.beat_cnt), 2);
    full_n[0] = 1'b1;
    wait_idle(0, 2, "t3 tail cycles");

    // reset mid-burst
    hdr(0, 2); word(0, 2, 0); word(0, 2, 1);
    hdr(0, 0); word(0, 0, 0);
    hdr(0, 1); word(0, 1, 0);
    hdr(0, 2); word(0, 2, 2); word(0, 2, 3);
    load(0, 2, 4);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    load(0, 0, 1);
    load(0, 1, 1);
    #1;
    chk("t6 gnt", 32'(gnt_v[0]), 0);
    chk("t6 wreq", 32'(wreq[0]), 0);
    chk("t6 busy", 32'(busy[0]), 0);
    chk("t6 cur_ch", 32'(cur_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(0, 13, "t6 cycles");

    // req drop during header
    hdr(0, 3);
    load(0, 3, 2);
    @(negedge clk);
    tot[0][3] = taken[0][3];
    wait_idle(0, 2, "t4 cycles");
    chk("t4 cur_ch", 32'(cur_v[0]), 3);
    hdr(0, 0); word(0, 0, 0);
    hdr(0, 3); word(0, 3, 0);
    load(0, 0, 1);
    load(0, 3, 1);
    wait_idle(0, 8, "t4b cycles");

    // no header, ch0 beats ch3 after ch3 served
    word(1, 3, 0); word(1, 3, 1);
    load(1, 3, 2);
    wait_idle(1, 4, "t5a cycles");
    word(1, 0, 0); word(1, 0, 1);
    word(1, 3, 0); word(1, 3, 1);
    load(1, 0, 2);
    load(1, 3, 2);
    wait_idle(1, 8, "t5 cycles");

    repeat (2) @(negedge clk);
    chk("q0 drained", 32'(q0.size()), 0);
    chk("q1 drained", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
